// File: rtl/airi5c_float_adder_generic_pkg.sv
// Shared constants and state encoding for the generic FP add/subtract core.
package airi5c_float_adder_generic_pkg;

  localparam logic [2:0] FPU_RM_RNE = 3'b000;
  localparam logic [2:0] FPU_RM_RDN = 3'b010;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_ALIGN = 5'b00010,
    S_ADD   = 5'b00100,
    S_NORM  = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;

endpackage

// File: rtl/airi5c_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports W.
module airi5c_lzc #(
  parameter int unsigned W = 24
) (
  input  logic [W-1:0]        din,
  output logic [$clog2(W):0]  cnt
);

  localparam int unsigned CW = $clog2(W) + 1;

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < int'(W); i++) begin
      if (din[i]) cnt = CW'(int'(W) - 1 - i);
    end
  end

endmodule

// File: rtl/airi5c_float_adder_generic.sv
// Multi-cycle FP add/subtract core: unrounded result plus round/sticky for the shared rounder.
module airi5c_float_adder_generic
  import airi5c_float_adder_generic_pkg::*;
#(
  parameter int unsigned MAN_W   = 24,
  parameter int unsigned EXP_W   = 10,
  parameter int unsigned EXP_INF = 255
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             kill,
  input  logic             load,
  input  logic             op_add,
  input  logic             op_sub,
  input  logic [2:0]       rm,
  input  logic [MAN_W-1:0] man_a,
  input  logic [MAN_W-1:0] man_b,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic             sgn_a,
  input  logic             sgn_b,
  input  logic             zero_a,
  input  logic             zero_b,
  input  logic             inf_a,
  input  logic             inf_b,
  input  logic             sNaN_a,
  input  logic             sNaN_b,
  input  logic             qNaN_a,
  input  logic             qNaN_b,
  output logic [MAN_W-1:0] man_y,
  output logic [EXP_W-1:0] exp_y,
  output logic             sgn_y,
  output logic             round_bit,
  output logic             sticky_bit,
  output logic             IV,
  output logic             final_res,
  output logic             ready,
  input  logic             res_ack
);

  // Extended operand: sign/carry bit, mantissa, guard, round.
  localparam int unsigned XW    = MAN_W + 3;
  localparam int unsigned SEL_W = $clog2(MAN_W + 3);
  localparam int unsigned LZ_W  = $clog2(MAN_W) + 1;

  typedef struct packed {
    logic [MAN_W-1:0] ma;
    logic [MAN_W-1:0] mb;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic             sgn;
    logic             sub;
    logic [XW-1:0]    b_al;
    logic [XW-1:0]    sum;
    logic             stk;
  } dp_t;

  typedef struct packed {
    logic [MAN_W-1:0] man;
    logic [EXP_W-1:0] ex;
    logic             sgn;
    logic             rnd;
    logic             stk;
    logic             iv;
    logic             final_res;
    logic             ready;
  } out_t;

  state_t state;
  dp_t    dp_r, load_dp_c;
  out_t   out_r, spec_c, norm_c;

  logic             abort_c, sgn_b_int, sub_c, swap_c, iv_c, nan_c, cancel_c, special_c;
  logic [EXP_W:0]   d_c;
  logic [SEL_W-1:0] shift_c;
  logic [XW-1:0]    b_ext_c, b_neg_c, b_sh_c;
  logic             stk_c;
  logic [MAN_W-1:0] mant_c;
  logic [LZ_W-1:0]  lz_c;

  assign abort_c   = kill || (load && !op_add && !op_sub);
  assign sgn_b_int = sgn_b ^ op_sub;
  assign sub_c     = sgn_a ^ sgn_b_int;
  assign swap_c    = (zero_a && !zero_b) || ($signed(exp_a) < $signed(exp_b)) ||
                     (exp_a == exp_b && man_a < man_b);
  assign iv_c      = sNaN_a || sNaN_b || (sub_c && inf_a && inf_b);
  assign nan_c     = iv_c || qNaN_a || qNaN_b;
  assign cancel_c  = sub_c && exp_a == exp_b && man_a == man_b;

  // Operand ordering and special-case results, evaluated on load.
  always_comb begin
    load_dp_c     = '0;
    load_dp_c.ma  = swap_c ? man_b : man_a;
    load_dp_c.mb  = swap_c ? man_a : man_b;
    load_dp_c.ea  = swap_c ? exp_b : exp_a;
    load_dp_c.eb  = swap_c ? exp_a : exp_b;
    load_dp_c.sgn = swap_c ? sgn_b_int : sgn_a;
    load_dp_c.sub = sub_c;

    spec_c       = '0;
    spec_c.ready = 1'b1;
    special_c    = 1'b1;
    if (nan_c) begin
      spec_c.man       = {2'b11, (MAN_W-2)'(0)};
      spec_c.ex        = EXP_W'(EXP_INF);
      spec_c.iv        = iv_c;
      spec_c.final_res = 1'b1;
    end else if (inf_a || inf_b) begin
      spec_c.man       = {1'b1, (MAN_W-1)'(0)};
      spec_c.ex        = EXP_W'(EXP_INF);
      spec_c.sgn       = inf_a ? sgn_a : sgn_b_int;
      spec_c.final_res = 1'b1;
    end else if (zero_a && zero_b) begin
      spec_c.sgn       = sgn_a & sgn_b_int;
      spec_c.final_res = 1'b1;
    end else if (cancel_c) begin
      spec_c.sgn       = (rm == FPU_RM_RDN);
      spec_c.final_res = 1'b1;
    end else if (zero_b) begin
      spec_c.man = man_a;
      spec_c.ex  = exp_a;
      spec_c.sgn = sgn_a;
    end else if (zero_a) begin
      spec_c.man = man_b;
      spec_c.ex  = exp_b;
      spec_c.sgn = sgn_b_int;
    end else begin
      special_c = 1'b0;
    end
  end

  // Alignment: saturate the shift so B fully drains into sticky.
  always_comb begin
    d_c     = {dp_r.ea[EXP_W-1], dp_r.ea} - {dp_r.eb[EXP_W-1], dp_r.eb};
    shift_c = (d_c > (EXP_W+1)'(MAN_W + 1)) ? SEL_W'(MAN_W + 2) : d_c[SEL_W-1:0];
    b_ext_c = {1'b0, dp_r.mb, 2'b00};
    b_neg_c = dp_r.sub ? (~b_ext_c + XW'(1)) : b_ext_c;
    b_sh_c  = XW'($signed(b_neg_c) >>> shift_c);
    stk_c   = |(b_neg_c & ~({XW{1'b1}} << shift_c));
  end

  assign mant_c = dp_r.sum[XW-2:2];

  airi5c_lzc #(.W(MAN_W)) u_lzc (
    .din (mant_c),
    .cnt (lz_c)
  );

  // Normalisation of the raw sum.
  always_comb begin
    norm_c       = '0;
    norm_c.ready = 1'b1;
    norm_c.sgn   = dp_r.sgn;
    if (dp_r.sum[XW-1] && !dp_r.sub) begin
      norm_c.man = dp_r.sum[XW-1:3];
      norm_c.ex  = dp_r.ea + EXP_W'(1);
      norm_c.rnd = dp_r.sum[2];
      norm_c.stk = dp_r.stk | dp_r.sum[1] | dp_r.sum[0];
    end else if (mant_c[MAN_W-1]) begin
      norm_c.man = mant_c;
      norm_c.ex  = dp_r.ea;
      norm_c.rnd = dp_r.sum[1];
      norm_c.stk = dp_r.stk | dp_r.sum[0];
    end else if (lz_c == LZ_W'(1)) begin
      norm_c.man = {mant_c[MAN_W-2:0], dp_r.sum[1]};
      norm_c.ex  = dp_r.ea - EXP_W'(1);
      norm_c.rnd = dp_r.sum[0];
      norm_c.stk = dp_r.stk;
    end else begin
      norm_c.man = MAN_W'(({mant_c, dp_r.sum[1:0]} << lz_c) >> 2);
      norm_c.ex  = dp_r.ea - EXP_W'(lz_c);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= S_IDLE;
      dp_r  <= '0;
      out_r <= '0;
    end else if (abort_c) begin
      state <= S_IDLE;
      dp_r  <= '0;
      out_r <= '0;
    end else if (load) begin
      dp_r <= load_dp_c;
      if (special_c) begin
        out_r <= spec_c;
        state <= S_DONE;
      end else begin
        out_r <= '0;
        state <= S_ALIGN;
      end
    end else begin
      case (state)
        S_ALIGN: begin
          dp_r.b_al <= b_sh_c;
          dp_r.stk  <= stk_c;
          state     <= S_ADD;
        end
        S_ADD: begin
          dp_r.sum <= {1'b0, dp_r.ma, 2'b00} + dp_r.b_al;
          state    <= S_NORM;
        end
        S_NORM: begin
          out_r <= norm_c;
          state <= S_DONE;
        end
        S_DONE: begin
          if (res_ack) begin
            out_r.ready <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign man_y      = out_r.man;
  assign exp_y      = out_r.ex;
  assign sgn_y      = out_r.sgn;
  assign round_bit  = out_r.rnd;
  assign sticky_bit = out_r.stk;
  assign IV         = out_r.iv;
  assign final_res  = out_r.final_res;
  assign ready      = out_r.ready;

endmodule

// File: tb/tb_airi5c_float_adder_generic.sv
// Directed bench for the generic FP adder: FP32 instance plus a FP16-sized instance.
module tb_airi5c_float_adder_generic;
  import airi5c_float_adder_generic_pkg::*;

  logic clk = 1'b0;
  logic n_reset, kill, load, op_add, op_sub, res_ack;
  logic [2:0] rm;
  logic sgn_a, sgn_b, zero_a, zero_b, inf_a, inf_b, sNaN_a, sNaN_b, qNaN_a, qNaN_b;

  logic [23:0] man_a, man_b, man_y;
  logic [9:0]  exp_a, exp_b, exp_y;
  logic        sgn_y, round_bit, sticky_bit, iv, final_res, ready;

  logic [10:0] man_a16, man_b16, man_y16;
  logic [6:0]  exp_a16, exp_b16, exp_y16;
  logic        sgn_y16, round_bit16, sticky_bit16, iv16, final_res16, ready16;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  always #5 clk = ~clk;

  airi5c_float_adder_generic u32 (
    .clk(clk), .n_reset(n_reset), .kill(kill), .load(load), .op_add(op_add), .op_sub(op_sub),
    .rm(rm), .man_a(man_a), .man_b(man_b), .exp_a(exp_a), .exp_b(exp_b),
    .sgn_a(sgn_a), .sgn_b(sgn_b), .zero_a(zero_a), .zero_b(zero_b), .inf_a(inf_a), .inf_b(inf_b),
    .sNaN_a(sNaN_a), .sNaN_b(sNaN_b), .qNaN_a(qNaN_a), .qNaN_b(qNaN_b),
    .man_y(man_y), .exp_y(exp_y), .sgn_y(sgn_y), .round_bit(round_bit), .sticky_bit(sticky_bit),
    .IV(iv), .final_res(final_res), .ready(ready), .res_ack(res_ack)
  );

  airi5c_float_adder_generic #(.MAN_W(11), .EXP_W(7), .EXP_INF(31)) u16 (
    .clk(clk), .n_reset(n_reset), .kill(kill), .load(load), .op_add(op_add), .op_sub(op_sub),
    .rm(rm), .man_a(man_a16), .man_b(man_b16), .exp_a(exp_a16), .exp_b(exp_b16),
    .sgn_a(sgn_a), .sgn_b(sgn_b), .zero_a(zero_a), .zero_b(zero_b), .inf_a(inf_a), .inf_b(inf_b),
    .sNaN_a(sNaN_a), .sNaN_b(sNaN_b), .qNaN_a(qNaN_a), .qNaN_b(qNaN_b),
    .man_y(man_y16), .exp_y(exp_y16), .sgn_y(sgn_y16), .round_bit(round_bit16),
    .sticky_bit(sticky_bit16), .IV(iv16), .final_res(final_res16), .ready(ready16), .res_ack(res_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clr_flags();
    {sgn_a, sgn_b, zero_a, zero_b, inf_a, inf_b, sNaN_a, sNaN_b, qNaN_a, qNaN_b} = '0;
  endtask

  task automatic ops(input logic [23:0] ma, input logic [9:0] ea, input logic [23:0] mb, input logic [9:0] eb);
    man_a = ma; exp_a = ea; man_b = mb; exp_b = eb;
  endtask

  // Pulse load at a falling edge and count rising edges until ready (bounded).
  task automatic start(input logic add, input logic sub, output int n);
    op_add = add; op_sub = sub; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 1;
    while (!ready && n < 12) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_ack();
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
  endtask

  initial begin
    n_reset = 1'b0; kill = 1'b0; load = 1'b0; op_add = 1'b0; op_sub = 1'b0; res_ack = 1'b0;
    rm = FPU_RM_RNE;
    clr_flags();
    ops(24'h0, 10'd0, 24'h0, 10'd0);
    man_a16 = 11'h400; exp_a16 = 7'd15; man_b16 = 11'h400; exp_b16 = 7'd15;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_man", 32'(man_y), 32'd0);
    chk("rst_exp", 32'(exp_y), 32'd0);
    n_reset = 1'b1;
    @(negedge clk);

    // 1.0 + 1.0 on both widths
    ops(24'h800000, 10'd127, 24'h800000, 10'd127);
    start(1'b1, 1'b0, cyc);
    chk("t1_latency", 32'(cyc), 32'd4);
    chk("t1_man", 32'(man_y), 32'h800000);
    chk("t1_exp", 32'(exp_y), 32'd128);
    chk("t1_rs", 32'({round_bit, sticky_bit, final_res, sgn_y}), 32'd0);
    chk("t1_fp16_man", 32'(man_y16), 32'h400);
    chk("t1_fp16_exp", 32'(exp_y16), 32'd16);
    repeat (3) @(negedge clk);
    chk("t1_hold_ready", 32'(ready), 32'd1);
    chk("t1_hold_man", 32'(man_y), 32'h800000);
    do_ack();
    chk("t1_ack_ready", 32'(ready), 32'd0);
    chk("t1_ack_ready16", 32'(ready16), 32'd0);

    // 1.0 - 1.0, RNE then RDN
    start(1'b0, 1'b1, cyc);
    chk("t2_latency", 32'(cyc), 32'd1);
    chk("t2_rne", 32'({man_y, exp_y, sgn_y, final_res}), 32'd1);
    do_ack();
    rm = FPU_RM_RDN;
    start(1'b0, 1'b1, cyc);
    chk("t2_rdn_sgn", 32'({sgn_y, final_res}), 32'd3);
    do_ack();
    rm = FPU_RM_RNE;

    // inf - inf is invalid
    ops(24'h800000, 10'd255, 24'h800000, 10'd255);
    inf_a = 1'b1; inf_b = 1'b1;
    start(1'b0, 1'b1, cyc);
    chk("t3_latency", 32'(cyc), 32'd1);
    chk("t3_iv", 32'({iv, final_res}), 32'd3);
    chk("t3_man", 32'(man_y), 32'hC00000);
    chk("t3_exp", 32'(exp_y), 32'd255);
    do_ack();
    clr_flags();

    // sNaN + 1.0
    ops(24'hA00000, 10'd255, 24'h800000, 10'd127);
    sNaN_a = 1'b1;
    start(1'b1, 1'b0, cyc);
    chk("t3b_iv", 32'(iv), 32'd1);
    chk("t3b_man", 32'(man_y), 32'hC00000);
    do_ack();
    clr_flags();

    // Deep cancellation
    ops(24'h800000, 10'd127, 24'hFFFFFF, 10'd126);
    start(1'b0, 1'b1, cyc);
    chk("t4_latency", 32'(cyc), 32'd4);
    chk("t4_man", 32'(man_y), 32'h800000);
    chk("t4_exp", 32'(exp_y), 32'd103);
    chk("t4_rs", 32'({round_bit, sticky_bit, sgn_y, final_res}), 32'd0);
    do_ack();

    // Operand fully shifted out, sticky kept
    ops(24'h800000, 10'd127, 24'h800001, 10'd97);
    start(1'b1, 1'b0, cyc);
    chk("t5_man", 32'(man_y), 32'h800000);
    chk("t5_exp", 32'(exp_y), 32'd127);
    chk("t5_rs", 32'({round_bit, sticky_bit}), 32'd1);
    do_ack();

    // 1.0 + (0.5 + ulp): round bit set, exact otherwise
    ops(24'h800000, 10'd127, 24'h800001, 10'd126);
    start(1'b1, 1'b0, cyc);
    chk("t7_man", 32'(man_y), 32'hC00000);
    chk("t7_rs", 32'({round_bit, sticky_bit}), 32'd2);
    do_ack();

    // 1.0 - 2.0 = -1.0 (swap, single-bit normalise)
    ops(24'h800000, 10'd127, 24'h800000, 10'd128);
    start(1'b0, 1'b1, cyc);
    chk("t8_man", 32'(man_y), 32'h800000);
    chk("t8_exp", 32'(exp_y), 32'd127);
    chk("t8_sgn", 32'({sgn_y, round_bit, sticky_bit}), 32'd4);
    // load without an operation aborts like kill
    op_add = 1'b0; op_sub = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("t8_abort", 32'({ready, sgn_y, man_y}), 32'd0);

    // 0 - 1.0 passes B through with inverted sign
    ops(24'h000000, 10'd0, 24'h800000, 10'd127);
    zero_a = 1'b1;
    start(1'b0, 1'b1, cyc);
    chk("t9_latency", 32'(cyc), 32'd1);
    chk("t9_man", 32'(man_y), 32'h800000);
    chk("t9_sgn", 32'({sgn_y, final_res, exp_y}), 32'((1 << 11) | 127));
    clr_flags();
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("t9_kill_done", 32'({ready, man_y, exp_y[7:0]}), 32'd0);

    // Kill while in ADD: no result ever appears
    ops(24'h800000, 10'd127, 24'h800000, 10'd127);
    op_add = 1'b1; op_sub = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("t6_kill_out", 32'({ready16, man_y16, exp_y16, sgn_y16}), 32'd0);
    repeat (5) @(negedge clk);
    chk("t6_kill_ready", 32'({ready, ready16}), 32'd0);
    chk("t6_kill_exp", 32'({exp_y, exp_y16}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
